wide_add_64: RTL and testbench

WIDE_ADD_64 -- requirements
Module: wide_add_64

---
 rtl/wide_add_64.sv | 124 ++++++++++++
 tb/tb_wide_add_64.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wide_add_64.sv
`default_nettype none
// ============================================================================
//  Module   : wide_add_64
//  Purpose  : 64-bit unsigned adder (A + B + cin) computed serially as four
//             16-bit slices, least significant first, through one shared
//             16-bit adder. Fixed latency of 5 cycles from accepted start
//             to the done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module wide_add_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
  output logic        cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic        carry_q;
  logic [1:0]  idx_q;
  logic [63:0] sum_q;
  logic        cout_q;
  logic        busy_q;
  logic        done_q;

  logic [15:0] a_slice_w;
  logic [15:0] b_slice_w;
  logic [16:0] add_w;

  // Select the active operand slice and add it with the running carry.
  always_comb begin
    a_slice_w = 16'h0000;
    b_slice_w = 16'h0000;
    case (idx_q)
      2'd0: begin a_slice_w = a_q[15:0];  b_slice_w = b_q[15:0];  end
      2'd1: begin a_slice_w = a_q[31:16]; b_slice_w = b_q[31:16]; end
      2'd2: begin a_slice_w = a_q[47:32]; b_slice_w = b_q[47:32]; end
      default: begin a_slice_w = a_q[63:48]; b_slice_w = b_q[63:48]; end
    endcase
    add_w = {1'b0, a_slice_w} + {1'b0, b_slice_w} + {16'h0000, carry_q};
  end

  // Next-state logic: IDLE -> ADD (4 slices) -> DONE (one cycle) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (idx_q == 2'd3) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and status registers; reset wipes any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 64'h0;
      b_q     <= 64'h0;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      sum_q   <= 64'h0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= cin;
            idx_q   <= 2'd0;
            busy_q  <= 1'b1;
          end
        end
        S_ADD: begin
          case (idx_q)
            2'd0:    sum_q[15:0]  <= add_w[15:0];
            2'd1:    sum_q[31:16] <= add_w[15:0];
            2'd2:    sum_q[47:32] <= add_w[15:0];
            default: sum_q[63:48] <= add_w[15:0];
          endcase
          carry_q <= add_w[16];
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cout_q <= add_w[16];
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_64.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wide_add_64
//  Purpose  : Self-checking bench for wide_add_64: fixed vector table,
//             randomized operands against a 65-bit arithmetic model, and
//             hand-written sequences for start-ignore, reset-abort and
//             back-to-back runs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_64;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] A;
  logic [63:0] B;
  logic        cin;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cout;

  int errors = 0;
  int checks = 0;

  wide_add_64 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        c;
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  // Reference: plain 65-bit arithmetic.
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {64'h0, c};
  endfunction

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One full operation: checks busy/done timing per cycle and the result.
  // Operands are scrambled right after capture to prove they are latched.
  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] es, input logic ec);
    @(negedge clk);
    start = 1'b1; A = a; B = b; cin = c;
    @(posedge clk);            // edge T
    @(negedge clk);            // cycle T+1
    start = 1'b0;
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; cin = 1'($urandom);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("%s busy/done T+%0d", name, k), {63'h0, busy, done}, 65'b10);
      @(negedge clk);
    end
    chk($sformatf("%s busy/done T+5", name), {63'h0, busy, done}, 65'b01);
    chk($sformatf("%s result", name), {cout, sum}, {ec, es});
    @(negedge clk);            // cycle T+6, IDLE: result held, no done
    chk($sformatf("%s hold T+6", name), {done, cout, sum}, {1'b0, ec, es});
  endtask

  initial begin
    logic [64:0] m;
    logic [63:0] ra, rb;
    logic        rc;
    int          done_cnt;
    int          t5_done;

    vecs[0] = '{64'h0000_0000_0000_FDE8, 64'h0000_0000_0000_FF3C, 1'b0, 64'h0000_0000_0001_FD24, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0001, 1'b1};
    vecs[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
    vecs[7] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; A = 64'h0; B = 64'h0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {busy, done, cout, sum}, '0);
    rst = 1'b0;

    // Start asserted together with reset must be ignored.
    rst = 1'b1; start = 1'b1; A = 64'h5; B = 64'h7;
    @(negedge clk);
    chk("rst over start", {busy, done}, '0);
    rst = 1'b0; start = 1'b0;

    // Vector table.
    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
      if (i % 4 == 0) ra[47:0] = '1;   // force long carry chains
      m = model(ra, rb, rc);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, m[63:0], m[64]);
    end

    // Start pulsed mid-run with new operands: ignored, single done at T+5.
    m = model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    @(negedge clk);
    start = 1'b1; A = 64'h0123_4567_89AB_CDEF; B = 64'hFEDC_BA98_7654_3210; cin = 1'b1;
    @(posedge clk);            // T
    @(negedge clk);            // T+1
    start = 1'b0;
    done_cnt = 0; t5_done = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 2) begin start = 1'b1; A = 64'h1; B = 64'h1; cin = 1'b0; end
      if (k == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (k == 5) begin
          t5_done = 1;
          chk("midstart result", {cout, sum}, m);
        end
      end
      @(negedge clk);
    end
    chk("midstart done at T+5", 65'(t5_done), 65'd1);
    chk("midstart done count", 65'(done_cnt), 65'd1);

    // Reset during ADD: abort, outputs zero, no done.
    @(negedge clk);
    start = 1'b1; A = 64'hFFFF_0000_FFFF_0000; B = 64'h0000_FFFF_0000_FFFF; cin = 1'b1;
    @(posedge clk);            // T
    @(negedge clk);            // T+1
    start = 1'b0;
    @(negedge clk);            // T+2
    @(negedge clk);            // T+3
    rst = 1'b1;
    @(negedge clk);            // T+4
    rst = 1'b0;
    chk("abort outputs T+4", {busy, done, cout, sum}, '0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("abort no done", 65'(done_cnt), 65'd0);
    do_op("after abort", vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].exp_sum, vecs[0].exp_cout);

    // Start held high: runs complete at T+5 and T+11.
    m = model(64'hDEAD_BEEF_CAFE_F00D, 64'h2152_4110_3501_0FF3, 1'b0);
    @(negedge clk);
    start = 1'b1; A = 64'hDEAD_BEEF_CAFE_F00D; B = 64'h2152_4110_3501_0FF3; cin = 1'b0;
    @(posedge clk);            // T
    @(negedge clk);            // T+1
    for (int k = 1; k <= 13; k++) begin
      if (k == 7) start = 1'b0;
      if (k == 5 || k == 11)
        chk($sformatf("b2b T+%0d", k), {62'h0, busy, done, cout, sum[0]}, {62'h0, 1'b0, 1'b1, m[64], m[0]});
      else if ((k >= 1 && k <= 4) || (k >= 7 && k <= 10))
        chk($sformatf("b2b T+%0d", k), {63'h0, busy, done}, 65'b10);
      else
        chk($sformatf("b2b T+%0d", k), {63'h0, busy, done}, 65'b00);
      if (k == 11) chk("b2b result", {cout, sum}, m);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
